// File: rtl/run_monitor_if.sv
// run_monitor_if: dump-side signals of the run monitor
// memory read port plus the valid/ready word stream
interface run_monitor_if #(
  parameter int DATA_W  = 32,
  parameter int MADDR_W = 16
);
  logic               mem_re;
  logic [MADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]  mem_rdata;
  logic               dump_valid;
  logic               dump_ready;
  logic [DATA_W-1:0]  dump_data;
  logic               dump_done;

  modport master (
    output mem_re, mem_addr,
    output dump_valid, dump_data, dump_done,
    input  mem_rdata, dump_ready
  );

  modport slave (
    input  mem_re, mem_addr,
    input  dump_valid, dump_data, dump_done,
    output mem_rdata, dump_ready
  );
endinterface

// File: rtl/run_monitor.sv
// run_monitor: run cycle/event counters, halted by a store
// to HALT_ADDR, followed by a streamed memory dump
module run_monitor #(
  parameter int DATA_W = 32,
  parameter int NEV = 4,
  parameter int CNT_W = 32,
  parameter logic [DATA_W-1:0] HALT_ADDR = DATA_W'(32'h7fff),
  parameter int DUMP_WORDS = 200,
  parameter int MADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [NEV-1:0]       ev,
  input  logic [DATA_W-1:0]    daddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic                 we,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [NEV*CNT_W-1:0] ev_cnt,
  output logic                 halted,
  output logic [DATA_W-1:0]    result,
  run_monitor_if.master        dm
);

  localparam logic [MADDR_W-1:0] LAST =
    MADDR_W'(DUMP_WORDS - 1);

  typedef enum logic [2:0] {
    S_RUN, S_RD, S_WT, S_OUT, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]          cyc_q;
  logic [NEV-1:0][CNT_W-1:0] evc_q;
  logic [MADDR_W-1:0]        idx_q;
  logic [DATA_W-1:0]         data_q;
  logic                      hit;
  logic                      last;
  logic                      run_en;

  assign hit    = (state_q == S_RUN) && we
                  && (daddr == HALT_ADDR);
  assign run_en = (state_q == S_RUN) && !hit;
  assign last   = (idx_q == LAST);

  assign cycle_cnt     = cyc_q;
  assign ev_cnt        = evc_q;
  assign dm.mem_re     = (state_q == S_RD);
  assign dm.mem_addr   = (state_q == S_RD) ? idx_q : '0;
  assign dm.dump_valid = (state_q == S_OUT);
  assign dm.dump_done  = (state_q == S_DONE);
  assign dm.dump_data  = data_q;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  // next-state: RUN until halt, then RD/WT/OUT per word
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN:  if (hit) state_d = S_RD;
      S_RD:   state_d = S_WT;
      S_WT:   state_d = S_OUT;
      S_OUT:  if (dm.dump_ready)
                state_d = last ? S_DONE : S_RD;
      S_DONE: state_d = S_DONE;
      default: state_d = S_RUN;
    endcase
  end

  // saturating counters; clear wins over increments
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      evc_q <= '0;
    end else if (run_en) begin
      if (clear) begin
        cyc_q <= '0;
        evc_q <= '0;
      end else begin
        if (cyc_q != '1)
          cyc_q <= cyc_q + CNT_W'(1);
        for (int k = 0; k < NEV; k++)
          if (ev[k] && evc_q[k] != '1)
            evc_q[k] <= evc_q[k] + CNT_W'(1);
      end
    end
  end

  // capture halt flag and stored result once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted <= 1'b0;
      result <= '0;
    end else if (hit) begin
      halted <= 1'b1;
      result <= wdata;
    end
  end

  // dump word index, advanced on each non-final accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idx_q <= '0;
    else if (hit)
      idx_q <= '0;
    else if (state_q == S_OUT && dm.dump_ready && !last)
      idx_q <= idx_q + MADDR_W'(1);
  end

  // latch read data one cycle after the request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      data_q <= '0;
    else if (state_q == S_WT)
      data_q <= dm.mem_rdata;
  end

endmodule

// File: doc/run_monitor.md
RUN_MONITOR -- requirements
Module: run_monitor

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data/address width of the monitored bus.
REQ-002 SHALL have parameter NEV, default 4, number of event counter channels (1..16).
REQ-003 SHALL have parameter CNT_W, default 32, width of every counter.
REQ-004 SHALL have parameter HALT_ADDR, default 32'h7fff, termination store address.
REQ-005 SHALL have parameter DUMP_WORDS, default 200, number of memory words dumped after halt (1..65536).
REQ-006 SHALL have parameter MADDR_W, default 16, word-address width of the dump read port.
REQ-007 clk  input  1  single clock; all state updates on posedge clk.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 clear  input  1  synchronous counter clear, honoured only in RUN.
REQ-010 ev  input  NEV  per-cycle event strobes (ev[0] is the CPU stall strobe by convention).
REQ-011 daddr  input  DATA_W  data-bus address.
REQ-012 wdata  input  DATA_W  data-bus write data.
REQ-013 we  input  1  data-bus write enable.
REQ-014 cycle_cnt  output  CNT_W  run cycle counter.
REQ-015 ev_cnt  output  NEV*CNT_W  event counters, channel k at bits [k*CNT_W +: CNT_W].
REQ-016 halted  output  1  termination store seen.
REQ-017 result  output  DATA_W  wdata captured at termination store.
REQ-018 mem_re  output  1  dump read request.
REQ-019 mem_addr  output  MADDR_W  dump word address.
REQ-020 mem_rdata  input  DATA_W  dump read data, valid exactly one cycle after mem_re.
REQ-021 dump_valid  output  1  dump_data holds a word.
REQ-022 dump_ready  input  1  consumer accepts the word.
REQ-023 dump_data  output  DATA_W  dumped word.
REQ-024 dump_done  output  1  all DUMP_WORDS words transferred.

Function
REQ-025 SHALL implement states RUN, RD, WT, OUT, DONE.
REQ-026 halt event = we && daddr == HALT_ADDR (full DATA_W compare), evaluated only in RUN.
REQ-027 In RUN without halt event: cycle_cnt +1 per cycle; ev_cnt[k] +1 per cycle with ev[k]=1.
REQ-028 All counters SHALL saturate at all-ones, no wrap.
REQ-029 clear in RUN (no halt) SHALL zero all counters that cycle; clear beats simultaneous increments.
REQ-030 On halt event: counters freeze at pre-halt values (halt cycle not counted, clear ignored); result <= wdata; halted <= 1; index <= 0; next state RD.
REQ-031 RD: mem_re=1, mem_addr=index (one cycle); next WT.
REQ-032 WT: dump_data <= mem_rdata; next OUT.
REQ-033 OUT: dump_valid=1, dump_data stable until dump_ready=1; on accept, if index==DUMP_WORDS-1 go DONE else index+1, go RD.
REQ-034 Latency: halt cycle to first dump_valid = 3 cycles; each word after accept = 3 cycles.
REQ-035 DONE: dump_done=1, dump_valid=0, mem_re=0; held until reset; all inputs ignored.
REQ-036 After halt, we/daddr/ev/clear SHALL have no effect; halted, result and counters stay constant.
REQ-037 mem_re SHALL be 0 outside RD; mem_addr SHALL be 0 when not dumping.

Reset
REQ-038 rst_n=0 SHALL immediately force RUN, all counters 0, halted 0, result 0, index 0, mem_re 0, mem_addr 0, dump_valid 0, dump_data 0, dump_done 0.
REQ-039 Reset asserted mid-dump SHALL abort the dump with no further mem_re; operation restarts in RUN after release.

Verification
REQ-040 Release reset, 10 idle cycles, store wdata=32'h1234 to 32'h7fff -> halted=1, result=32'h1234, cycle_cnt=10.
REQ-041 ev[0] high 7 of 20 cycles, ev[0] also high on halt cycle -> ev_cnt[0]=7.
REQ-042 CNT_W=4, 20 run cycles -> cycle_cnt=4'hf.
REQ-043 clear with ev[1]=1 at cycle 5, halt at cycle 9 -> cycle_cnt=3, ev_cnt[1] counts only cycles 6..8.
REQ-044 DUMP_WORDS=3, dump_ready low 4 cycles on word 1 -> mem_addr sequence 0,1,2; dump_data held stable while stalled; dump_done after third accept.
REQ-045 Reset during OUT of word 1, then halt again -> dump restarts at mem_addr 0, counters from zero.
